pla_vector_driver: RTL and testbench

//  Sequential harness stage placed directly upstream of a combinational PLA-projection block.
//  - Accepts input vectors over a valid/ready stream.
//  - Registers each vector onto the block's x bus and waits a fixed settle time.
//  - Samples the block's single output y.
//  - Emits {vector, y} over an output valid/ready stream.
//  - Keeps a vector count, a count of y==1 responses, and a MISR signature of the responses.

---
 rtl/pla_vector_driver.sv | 78 +++++++
 tb/tb_pla_vector_driver.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pla_vector_driver.sv
// pla_vector_driver: launches each accepted vector onto the PLA x bus, samples y after SETTLE cycles,
// streams {vector, y} out and accumulates vector count, ones count and a MISR signature.
module pla_vector_driver #(
   parameter int               N_IN     = 15,
   parameter int               SETTLE   = 1,
   parameter int               CNT_W    = 16,
   parameter int               SIG_W    = 16,
   parameter logic [SIG_W-1:0] SIG_POLY = 16'h1021,
   parameter logic [SIG_W-1:0] SIG_SEED = 16'h0000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N_IN-1:0]  in_vec,
   output logic [N_IN-1:0]  x_drv,
   input  logic             y_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N_IN-1:0]  out_vec,
   output logic             out_y,
   output logic [CNT_W-1:0] vec_cnt,
   output logic [CNT_W-1:0] ones_cnt,
   output logic [SIG_W-1:0] sig
);
   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_t;
   state_t           state, nxt;
   logic [7:0]       cnt;
   logic             accept, capture, done;
   logic [SIG_W-1:0] sig_nxt;
   assign in_ready = state == S_IDLE;
   assign sig_nxt  = (sig << 1) ^ (sig[SIG_W-1] ? SIG_POLY : '0) ^ SIG_W'(y_in);
   always_ff @(posedge clk)
      state <= !rst_n ? S_IDLE : nxt;
   always_comb begin
      accept  = state == S_IDLE && in_valid;
      capture = state == S_SETTLE && cnt == 8'd0;
      done    = state == S_HOLD && out_ready;
      nxt     = accept ? S_SETTLE : capture ? S_HOLD : done ? S_IDLE : state;
   end
   // clr only touches the statistics and beats a simultaneous capture
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x_drv     <= '0;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_vec   <= '0;
         out_y     <= 1'b0;
         vec_cnt   <= '0;
         ones_cnt  <= '0;
         sig       <= SIG_SEED;
      end else begin
         if (accept) begin
            x_drv <= in_vec;
            cnt   <= 8'(SETTLE - 1);
         end else if (state == S_SETTLE && cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
         end
         if (capture) begin
            out_vec   <= x_drv;
            out_y     <= y_in;
            out_valid <= 1'b1;
         end else if (done) begin
            out_valid <= 1'b0;
         end
         if (clr) begin
            vec_cnt  <= '0;
            ones_cnt <= '0;
            sig      <= SIG_SEED;
         end else if (capture) begin
            vec_cnt  <= vec_cnt + CNT_W'(1);
            ones_cnt <= ones_cnt + CNT_W'(y_in);
            sig      <= sig_nxt;
         end
      end
   end
endmodule

// File: tb/tb_pla_vector_driver.sv
// tb_pla_vector_driver: table vectors, hand-written corner sequences and randomized transactions
// checked against a transaction-level model; second instance covers SETTLE=4 and counter wrap.
module tb_pla_vector_driver;
   logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, b_clr = 1'b0;
   logic a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0, a_out_y, a_y;
   logic [14:0] a_in_vec = '0, a_x, a_out_vec;
   logic [15:0] a_vec_cnt, a_ones_cnt, a_sig;
   logic b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1, b_out_y, b_y;
   logic [14:0] b_in_vec = '0, b_x, b_out_vec;
   logic [3:0]  b_vec_cnt, b_ones_cnt;
   logic [15:0] b_sig;
   int n_cmp = 0, n_bad = 0;
   logic [15:0] m_cnt = '0, m_ones = '0, m_sig = '0;
   logic [3:0]  mb_cnt = '0, mb_ones = '0;
   logic [15:0] mb_sig = '0;
   typedef struct {
      logic [14:0] vec;
      logic        y;
      logic [15:0] sig;
      logic [15:0] ones;
      logic [15:0] cnt;
   } vec_t;
   vec_t tbl[5];
   assign a_y = a_x[0];
   assign b_y = b_x[0];
   always #5 clk = ~clk;
   pla_vector_driver dut_a (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_vec(a_in_vec), .x_drv(a_x), .y_in(a_y), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_vec(a_out_vec), .out_y(a_out_y), .vec_cnt(a_vec_cnt), .ones_cnt(a_ones_cnt), .sig(a_sig)
   );
   pla_vector_driver #(.SETTLE(4), .CNT_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .clr(b_clr), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_vec(b_in_vec), .x_drv(b_x), .y_in(b_y), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_vec(b_out_vec), .out_y(b_out_y), .vec_cnt(b_vec_cnt), .ones_cnt(b_ones_cnt), .sig(b_sig)
   );
   function automatic logic [15:0] misr(input logic [15:0] s, input logic y);
      return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'h0, y};
   endfunction
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   task automatic a_stats;
      chk("a_vec_cnt", a_vec_cnt, m_cnt);
      chk("a_ones_cnt", a_ones_cnt, m_ones);
      chk("a_sig", a_sig, m_sig);
   endtask
   // one full transaction on dut_a: accept, capture one edge later, hold for `hold` cycles, release
   task automatic a_xact(input logic [14:0] v, input int hold, input logic cc);
      chk("a_in_ready_idle", a_in_ready, 1);
      a_in_vec = v;
      a_in_valid = 1'b1;
      a_out_ready = 1'($urandom);
      step;
      a_in_valid = 1'b0;
      a_in_vec = 15'($urandom);
      chk("a_x_drv_launch", a_x, v);
      chk("a_in_ready_settle", a_in_ready, 0);
      chk("a_out_valid_settle", a_out_valid, 0);
      clr = cc;
      step;
      clr = 1'b0;
      if (cc) begin
         m_cnt = '0; m_ones = '0; m_sig = '0;
      end else begin
         m_cnt++; m_ones += 16'(v[0]); m_sig = misr(m_sig, v[0]);
      end
      chk("a_out_valid_cap", a_out_valid, 1);
      chk("a_out_vec_cap", a_out_vec, v);
      chk("a_out_y_cap", a_out_y, v[0]);
      chk("a_in_ready_hold", a_in_ready, 0);
      a_stats();
      for (int i = 0; i < hold; i++) begin
         a_out_ready = 1'b0;
         a_in_valid = 1'($urandom);
         a_in_vec = 15'($urandom);
         step;
         chk("a_out_valid_hold", a_out_valid, 1);
         chk("a_out_vec_hold", a_out_vec, v);
         chk("a_out_y_hold", a_out_y, v[0]);
         chk("a_x_drv_hold", a_x, v);
         chk("a_in_ready_hold", a_in_ready, 0);
      end
      a_in_valid = 1'b0;
      a_out_ready = 1'b1;
      step;
      a_out_ready = 1'b0;
      chk("a_out_valid_rel", a_out_valid, 0);
      chk("a_in_ready_rel", a_in_ready, 1);
      chk("a_x_drv_rel", a_x, v);
      a_stats();
   endtask
   // dut_b has SETTLE=4: capture exactly four edges after accept, x_drv frozen meanwhile
   task automatic b_xact(input logic [14:0] v);
      chk("b_in_ready_idle", b_in_ready, 1);
      b_in_vec = v;
      b_in_valid = 1'b1;
      step;
      b_in_valid = 1'b0;
      for (int k = 1; k < 4; k++) begin
         chk("b_x_drv_settle", b_x, v);
         chk("b_in_ready_settle", b_in_ready, 0);
         chk("b_out_valid_settle", b_out_valid, 0);
         b_in_vec = 15'($urandom);
         b_in_valid = 1'($urandom);
         step;
      end
      b_in_valid = 1'b0;
      chk("b_x_drv_settle", b_x, v);
      chk("b_out_valid_early", b_out_valid, 0);
      step;
      mb_cnt++; mb_ones += 4'(v[0]); mb_sig = misr(mb_sig, v[0]);
      chk("b_out_valid_cap", b_out_valid, 1);
      chk("b_out_vec_cap", b_out_vec, v);
      chk("b_out_y_cap", b_out_y, v[0]);
      chk("b_x_drv_cap", b_x, v);
      chk("b_vec_cnt", b_vec_cnt, mb_cnt);
      chk("b_ones_cnt", b_ones_cnt, mb_ones);
      chk("b_sig", b_sig, mb_sig);
      step;
      chk("b_out_valid_rel", b_out_valid, 0);
      chk("b_in_ready_rel", b_in_ready, 1);
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end
   initial begin
      tbl[0] = '{15'h0001, 1'b1, 16'h0001, 16'd1, 16'd1};
      tbl[1] = '{15'h0003, 1'b1, 16'h0003, 16'd2, 16'd2};
      tbl[2] = '{15'h0002, 1'b0, 16'h0006, 16'd2, 16'd3};
      tbl[3] = '{15'h7FFF, 1'b1, 16'h000D, 16'd3, 16'd4};
      tbl[4] = '{15'h7FFE, 1'b0, 16'h001A, 16'd3, 16'd5};
      step;
      step;
      rst_n = 1'b1;
      chk("rst_x_drv", a_x, 0);
      chk("rst_out_valid", a_out_valid, 0);
      chk("rst_out_vec", a_out_vec, 0);
      chk("rst_out_y", a_out_y, 0);
      chk("rst_in_ready", a_in_ready, 1);
      a_stats();
      chk("rst_b_in_ready", b_in_ready, 1);
      chk("rst_b_sig", b_sig, 0);
      for (int i = 0; i < 5; i++) begin
         a_xact(tbl[i].vec, 0, 1'b0);
         chk("tbl_out_y", a_out_y, tbl[i].y);
         chk("tbl_sig", a_sig, tbl[i].sig);
         chk("tbl_ones", a_ones_cnt, tbl[i].ones);
         chk("tbl_cnt", a_vec_cnt, tbl[i].cnt);
      end
      a_xact(15'h1234, 10, 1'b0);
      a_xact(15'h0005, 1, 1'b1);
      chk("clr_cap_cnt", a_vec_cnt, 0);
      chk("clr_cap_sig", a_sig, 0);
      a_xact(15'h0011, 0, 1'b0);
      a_in_vec = 15'h0007;
      a_in_valid = 1'b1;
      step;
      a_in_valid = 1'b0;
      rst_n = 1'b0;
      step;
      rst_n = 1'b1;
      m_cnt = '0; m_ones = '0; m_sig = '0;
      chk("midrst_out_valid", a_out_valid, 0);
      chk("midrst_in_ready", a_in_ready, 1);
      chk("midrst_x_drv", a_x, 0);
      step;
      chk("midrst_no_cap", a_out_valid, 0);
      a_stats();
      for (int n = 0; n < 250; n++) begin
         if ($urandom_range(7) == 0) begin
            clr = 1'b1;
            step;
            clr = 1'b0;
            m_cnt = '0; m_ones = '0; m_sig = '0;
            a_stats();
         end
         for (int g = $urandom_range(2); g > 0; g--) begin
            a_in_vec = 15'($urandom);
            step;
            chk("idle_x_hold", a_out_valid, 0);
         end
         a_xact(15'($urandom), $urandom_range(3), $urandom_range(9) == 0);
      end
      for (int n = 0; n < 18; n++) b_xact(15'($urandom) | 15'h0001);
      chk("b_wrap_cnt", b_vec_cnt, 4'd2);
      chk("b_wrap_ones", b_ones_cnt, 4'd2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
